multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit, 4-register processor datapath (ops: 00 add, 01 load, 10 store, 11 branch).
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath control strobes and waits on instruction- and data-memory handshakes.
- Supports run and single-step modes, stops on a self-branch, and counts retired instructions.

Parameters:
- WAIT_LIMIT, 15: maximum cycles in MEM waiting for mem_ready before a fault.
- COUNT_W, 16: width of the retired-instruction counter.
- HALT_ON_SELF, 1: when 1, a branch with offset -1 (target == own PC) enters HALT.

Ports:
- clock  in  1  system clock (divided 1 Hz clock in the board build)
- reset  in  1  synchronous, active-high reset
- run  in  1  level; execute continuously while high
- step  in  1  one-cycle pulse; execute exactly one instruction when sampled in IDLE
- instr_valid  in  1  instruction memory has valid data on instr
- instr  in  8  instruction byte
- mem_ready  in  1  data memory has completed the current read or write
- fetch_req  out  1  request to instruction memory at the current PC
- ir_write  out  1  latch instr into IR
- ir  out  8  registered copy of the current instruction
- reg_write  out  1  register-file write strobe
- reg_dst  out  1  1 = write ir[1:0] (add); 0 = write ir[3:2] (load)
- alu_src  out  1  1 = sign-extended immediate; 0 = register operand
- mem_read  out  1  data-memory read request
- mem_write  out  1  data-memory write request
- mem_to_reg  out  1  writeback source is memory
- pc_write  out  1  PC update strobe
- pc_src_branch  out  1  with pc_write: PC <= PC+1+imm; otherwise PC <= PC+1
- busy  out  1  FSM is not in IDLE or HALT
- halted  out  1  FSM is in HALT
- fault  out  1  sticky: WAIT_LIMIT was exceeded
- state  out  3  current state encoding, for debug LEDs
- instr_count  out  COUNT_W  count of retired instructions

Behaviour:
- Reset (synchronous, highest priority, including mid-instruction): state=IDLE, ir=0, instr_count=0, fault=0; every strobe, busy and halted are 0.
- imm = sign-extended 2-bit field {ir[1] repeated x7, ir[0]}; its range is -2..+1.
- Strobes are Moore outputs decoded from state and ir. They are asserted only in the states listed below and are 0 everywhere else.
- IDLE:
  - If run=1 or step=1, go to FETCH.
  - If both are high, run dominates.
  - step is ignored in every state except IDLE.
- FETCH:
  - fetch_req=1 while waiting.
  - When instr_valid=1: ir_write=1, ir<=instr, go to DECODE.
  - There is no timeout in FETCH.
- DECODE: one cycle; go to EXEC.
- EXEC: one cycle; the ALU settles. Next state by opcode:
  - 00 (add): go to WB.
  - 01 (load) or 10 (store): go to MEM.
  - 11 (branch) with HALT_ON_SELF=1 and ir[1:0]==2'b11: go to HALT. No PC update; the instruction is not retired.
  - 11 (branch), all other cases: go to DONE with branch retirement.
- MEM:
  - Load: alu_src=1, mem_read=1.
  - Store: alu_src=1, mem_write=1.
  - The strobe is held until mem_ready=1. Then a load goes to WB and a store goes to DONE.
  - The wait counter resets on entry.
  - If the counter reaches WAIT_LIMIT with no mem_ready: set fault, drop the strobe, go to HALT.
  - mem_ready in the entry cycle completes in 1 cycle.
- WB: one cycle, reg_write=1.
  - Add: reg_dst=1, alu_src=0, mem_to_reg=0.
  - Load: reg_dst=0, alu_src=1, mem_to_reg=1.
  - Go to DONE.
- DONE: one cycle.
  - pc_write=1; pc_src_branch=1 only for a branch.
  - instr_count increments and wraps at 2^COUNT_W-1 to 0.
  - If run=1 go to FETCH, else go to IDLE.
- HALT: halted=1; leaves only on reset.
- Cycles per instruction, with zero wait states and instr_valid in the first FETCH cycle:
  - add: FETCH, DECODE, EXEC, WB, DONE = 5.
  - load: FETCH, DECODE, EXEC, MEM, WB, DONE = 6.
  - store: FETCH, DECODE, EXEC, MEM, DONE = 5.
  - branch: FETCH, DECODE, EXEC, DONE = 4.
- Dropping run mid-instruction does not abort; the current instruction completes through DONE, then the FSM goes to IDLE.
- instr and instr_valid are ignored outside FETCH. mem_ready is ignored outside MEM.
- busy = state is not IDLE and not HALT.

Decomposition:
- Shared package holds:
  - opcode constants: OP_ADD=2'b00, OP_LOAD=2'b01, OP_STORE=2'b10, OP_BRANCH=2'b11;
  - state encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, DONE=6, HALT=7;
  - the imm sign-extension function.
- One combinational sub-module, seq_ctrl_decode: maps (state, ir[7:6]) to the strobe set. The FSM, counters and registers stay in the top module.

Test Plan:
- Reset mid-MEM (store stalled, mem_ready=0): assert reset for 1 cycle -> next cycle state=0, all strobes 0, instr_count=0, fault=0.
- run=1, instr=8'b00_01_10_11 (add), instr_valid and mem_ready always 1 -> reg_write=1 with reg_dst=1 in cycle 4, pc_write=1 in cycle 5, instr_count=1 after 5 cycles; FETCH again in cycle 6.
- step pulse with instr=8'b01_00_01_01 (load), mem_ready delayed 3 cycles -> mem_read held for 4 cycles, reg_write with mem_to_reg=1 and reg_dst=0, then IDLE after 9 cycles; instr_count=1.
- Branch instr=8'b11_00_00_01 (imm=+1) -> pc_write=1 with pc_src_branch=1 in cycle 4; instr=8'b11_00_00_11 (imm=-1) -> halted=1 after EXEC; count unchanged; run toggling has no effect until reset.
- Store with mem_ready stuck at 0 and WAIT_LIMIT=15 -> mem_write is high for 15 cycles, then fault=1 and halted=1.
- With COUNT_W=4, retire 16 add instructions -> instr_count wraps from 15 to 0; run and step high together in IDLE -> continuous execution.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, state encodings,
// the strobe bundle and the immediate sign-extension helper.
package multicycle_sequencer_pkg;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StDone   = 3'd6,
    StHalt   = 3'd7
  } state_e;

  // Datapath strobes that depend only on state and opcode.
  typedef struct packed {
    logic fetch_req;
    logic reg_write;
    logic reg_dst;
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic pc_write;
    logic pc_src_branch;
  } strobes_t;

  // 2-bit immediate {ir[1], ir[0]} sign-extended to 8 bits (-2..+1).
  function automatic logic [7:0] sext_imm(input logic [1:0] field);
    return {{7{field[1]}}, field[0]};
  endfunction

endpackage

// File: rtl/seq_ctrl_decode.sv
// Combinational strobe decoder: maps the current state and opcode to the
// datapath control strobes. Everything not listed for a state stays 0.
module seq_ctrl_decode
  import multicycle_sequencer_pkg::*;
(
  input  state_e     state_i,
  input  logic [1:0] op_i,
  output strobes_t   strobes_o
);

  // Moore decode of state and opcode into the strobe set
  always_comb begin
    strobes_o = '0;
    unique case (state_i)
      StFetch: strobes_o.fetch_req = 1'b1;
      StMem: begin
        if (op_i == OP_LOAD) begin
          strobes_o.alu_src  = 1'b1;
          strobes_o.mem_read = 1'b1;
        end else if (op_i == OP_STORE) begin
          strobes_o.alu_src   = 1'b1;
          strobes_o.mem_write = 1'b1;
        end
      end
      StWb: begin
        strobes_o.reg_write = 1'b1;
        if (op_i == OP_ADD) begin
          strobes_o.reg_dst = 1'b1;
        end else if (op_i == OP_LOAD) begin
          strobes_o.alu_src    = 1'b1;
          strobes_o.mem_to_reg = 1'b1;
        end
      end
      StDone: begin
        strobes_o.pc_write      = 1'b1;
        strobes_o.pc_src_branch = (op_i == OP_BRANCH);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 8-bit, 4-register datapath. Steps each
// instruction through fetch/decode/exec/mem/wb/done, handles memory
// handshakes with a bounded wait, and counts retired instructions.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT   = 15,
  parameter int unsigned COUNT_W      = 16,
  parameter int unsigned HALT_ON_SELF = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               instr_valid,
  input  logic [7:0]         instr,
  input  logic               mem_ready,
  output logic               fetch_req,
  output logic               ir_write,
  output logic [7:0]         ir,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               alu_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               pc_write,
  output logic               pc_src_branch,
  output logic               busy,
  output logic               halted,
  output logic               fault,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_LIMIT - 1);

  state_e             state_q, state_d;
  logic [7:0]         ir_q, ir_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               fault_q, fault_d;
  logic               ir_load;
  strobes_t           strobes;

  // Next-state, IR capture, wait counter, fault and retire counter
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    count_d = count_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    ir_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run || step) state_d = StFetch;
      end
      StFetch: begin
        if (instr_valid) begin
          ir_load = 1'b1;
          ir_d    = instr;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        // Clear the wait counter so every MEM visit starts from zero
        wait_d = '0;
        unique case (ir_q[7:6])
          OP_ADD:            state_d = StWb;
          OP_LOAD, OP_STORE: state_d = StMem;
          default: begin
            // Self-branch (offset -1) would spin forever; park in HALT unretired
            if ((HALT_ON_SELF != 0) && (ir_q[1:0] == 2'b11)) state_d = StHalt;
            else                                             state_d = StDone;
          end
        endcase
      end
      StMem: begin
        if (mem_ready) begin
          state_d = (ir_q[7:6] == OP_LOAD) ? StWb : StDone;
        end else if (wait_q == WaitLast) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWb: state_d = StDone;
      StDone: begin
        count_d = count_q + COUNT_W'(1);
        state_d = run ? StFetch : StIdle;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
      count_q <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  seq_ctrl_decode u_decode (
    .state_i   (state_q),
    .op_i      (ir_q[7:6]),
    .strobes_o (strobes)
  );

  assign fetch_req     = strobes.fetch_req;
  assign ir_write      = ir_load;
  assign ir            = ir_q;
  assign reg_write     = strobes.reg_write;
  assign reg_dst       = strobes.reg_dst;
  assign alu_src       = strobes.alu_src;
  assign mem_read      = strobes.mem_read;
  assign mem_write     = strobes.mem_write;
  assign mem_to_reg    = strobes.mem_to_reg;
  assign pc_write      = strobes.pc_write;
  assign pc_src_branch = strobes.pc_src_branch;
  assign busy          = (state_q != StIdle) && (state_q != StHalt);
  assign halted        = (state_q == StHalt);
  assign fault         = fault_q;
  assign state         = state_q;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a cycle-by-cycle vector table plus
// hand sequences for wrap, reset mid-MEM, wait fault and self-branch halt.
module tb_multicycle_sequencer;

  localparam logic [9:0] SNone  = 10'b00_0000_0000;
  localparam logic [9:0] SFv    = 10'b11_0000_0000; // fetch_req + ir_write
  localparam logic [9:0] SFw    = 10'b10_0000_0000; // fetch_req only
  localparam logic [9:0] SWbAdd = 10'b00_1100_0000;
  localparam logic [9:0] SWbLd  = 10'b00_1010_0100;
  localparam logic [9:0] SMemLd = 10'b00_0011_0000;
  localparam logic [9:0] SMemSt = 10'b00_0010_1000;
  localparam logic [9:0] SDone  = 10'b00_0000_0010;
  localparam logic [9:0] SDoneB = 10'b00_0000_0011;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, run, step, instr_valid, mem_ready;
  logic [7:0] instr;

  logic a_fetch_req, a_ir_write, a_reg_write, a_reg_dst, a_alu_src, a_mem_read;
  logic a_mem_write, a_mem_to_reg, a_pc_write, a_pc_src_branch, a_busy, a_halted, a_fault;
  logic [7:0]  a_ir;
  logic [2:0]  a_state;
  logic [15:0] a_count;

  logic b_fetch_req, b_ir_write, b_reg_write, b_reg_dst, b_alu_src, b_mem_read;
  logic b_mem_write, b_mem_to_reg, b_pc_write, b_pc_src_branch, b_busy, b_halted, b_fault;
  logic [7:0]  b_ir;
  logic [2:0]  b_state;
  logic [3:0]  b_count;

  logic [9:0] a_stb, b_stb;
  assign a_stb = {a_fetch_req, a_ir_write, a_reg_write, a_reg_dst, a_alu_src, a_mem_read,
                  a_mem_write, a_mem_to_reg, a_pc_write, a_pc_src_branch};
  assign b_stb = {b_fetch_req, b_ir_write, b_reg_write, b_reg_dst, b_alu_src, b_mem_read,
                  b_mem_write, b_mem_to_reg, b_pc_write, b_pc_src_branch};

  multicycle_sequencer dut (
    .clock(clock), .reset(reset), .run(run), .step(step), .instr_valid(instr_valid),
    .instr(instr), .mem_ready(mem_ready), .fetch_req(a_fetch_req), .ir_write(a_ir_write),
    .ir(a_ir), .reg_write(a_reg_write), .reg_dst(a_reg_dst), .alu_src(a_alu_src),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_to_reg(a_mem_to_reg),
    .pc_write(a_pc_write), .pc_src_branch(a_pc_src_branch), .busy(a_busy),
    .halted(a_halted), .fault(a_fault), .state(a_state), .instr_count(a_count)
  );

  multicycle_sequencer #(.COUNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .run(run), .step(step), .instr_valid(instr_valid),
    .instr(instr), .mem_ready(mem_ready), .fetch_req(b_fetch_req), .ir_write(b_ir_write),
    .ir(b_ir), .reg_write(b_reg_write), .reg_dst(b_reg_dst), .alu_src(b_alu_src),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_to_reg(b_mem_to_reg),
    .pc_write(b_pc_write), .pc_src_branch(b_pc_src_branch), .busy(b_busy),
    .halted(b_halted), .fault(b_fault), .state(b_state), .instr_count(b_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Compare both instances against one expected state/strobe/count/fault set
  task automatic check_all(input string tag, input logic [2:0] est, input logic [9:0] estb,
                           input int ecnt, input logic efault);
    logic ebusy;
    ebusy = (est != 3'd0) && (est != 3'd7);
    chk({tag, ".state"},   32'(a_state),  32'(est));
    chk({tag, ".strobes"}, 32'(a_stb),    32'(estb));
    chk({tag, ".count"},   32'(a_count),  32'(ecnt % 65536));
    chk({tag, ".busy"},    32'(a_busy),   32'(ebusy));
    chk({tag, ".halted"},  32'(a_halted), 32'(est == 3'd7));
    chk({tag, ".fault"},   32'(a_fault),  32'(efault));
    chk({tag, ".w4state"}, 32'(b_state),  32'(est));
    chk({tag, ".w4strb"},  32'(b_stb),    32'(estb));
    chk({tag, ".w4count"}, 32'(b_count),  32'(ecnt % 16));
    chk({tag, ".w4fault"}, 32'(b_fault),  32'(efault));
  endtask

  // Caller sits at a negedge; one reset cycle, returns at the following negedge
  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       run;
    logic       step;
    logic       iv;
    logic [7:0] instr;
    logic       mr;
    logic [2:0] st;
    logic [9:0] stb;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic s, input logic iv, input logic [7:0] i,
                              input logic mr, input logic [2:0] st, input logic [9:0] stb,
                              input int cnt);
    vec_t v;
    v.run = r; v.step = s; v.iv = iv; v.instr = i; v.mr = mr; v.st = st; v.stb = stb;
    v.cnt = cnt;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    reset = 1'b1; run = 1'b0; step = 1'b0; instr_valid = 1'b0; instr = 8'hFF; mem_ready = 1'b0;

    // add (run), then branch +1 with run dropped
    tbl.push_back(mk(1, 0, 1, 8'h1B, 1, 3'd0, SNone,  0));
    tbl.push_back(mk(1, 0, 1, 8'h1B, 1, 3'd1, SFv,    0));
    tbl.push_back(mk(1, 0, 1, 8'h1B, 1, 3'd2, SNone,  0));
    tbl.push_back(mk(1, 0, 1, 8'h1B, 1, 3'd3, SNone,  0));
    tbl.push_back(mk(1, 0, 1, 8'h1B, 1, 3'd5, SWbAdd, 0));
    tbl.push_back(mk(1, 0, 1, 8'h1B, 1, 3'd6, SDone,  0));
    tbl.push_back(mk(0, 0, 1, 8'hC1, 1, 3'd1, SFv,    1));
    tbl.push_back(mk(0, 0, 1, 8'hC1, 1, 3'd2, SNone,  1));
    tbl.push_back(mk(0, 0, 1, 8'hC1, 1, 3'd3, SNone,  1));
    tbl.push_back(mk(0, 0, 1, 8'hC1, 1, 3'd6, SDoneB, 1));
    tbl.push_back(mk(0, 0, 1, 8'hC1, 1, 3'd0, SNone,  2));
    // step-driven load with a fetch wait and mem_ready on the 4th MEM cycle
    tbl.push_back(mk(0, 1, 0, 8'h45, 0, 3'd0, SNone,  2));
    tbl.push_back(mk(0, 1, 0, 8'h45, 0, 3'd1, SFw,    2));
    tbl.push_back(mk(0, 0, 1, 8'h45, 0, 3'd1, SFv,    2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'd2, SNone,  2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'd3, SNone,  2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'd4, SMemLd, 2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'd4, SMemLd, 2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'd4, SMemLd, 2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3'd4, SMemLd, 2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'd5, SWbLd,  2));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 3'd6, SDone,  2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'd0, SNone,  3));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 3'd0, SNone,  3));
    // store with immediate mem_ready, run dropped mid-instruction
    tbl.push_back(mk(1, 0, 1, 8'h80, 1, 3'd0, SNone,  3));
    tbl.push_back(mk(1, 0, 1, 8'h80, 1, 3'd1, SFv,    3));
    tbl.push_back(mk(0, 0, 1, 8'h80, 1, 3'd2, SNone,  3));
    tbl.push_back(mk(0, 0, 1, 8'h80, 1, 3'd3, SNone,  3));
    tbl.push_back(mk(0, 0, 1, 8'h80, 1, 3'd4, SMemSt, 3));
    tbl.push_back(mk(0, 0, 1, 8'h80, 1, 3'd6, SDone,  3));
    tbl.push_back(mk(0, 0, 1, 8'h80, 1, 3'd0, SNone,  4));

    @(negedge clock);
    #1;
    check_all("reset", 3'd0, SNone, 0, 1'b0);
    chk("reset.ir", 32'(a_ir), 32'h0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      run = tbl[i].run; step = tbl[i].step; instr_valid = tbl[i].iv;
      instr = tbl[i].instr; mem_ready = tbl[i].mr;
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].stb, tbl[i].cnt, 1'b0);
      if (i == 14) chk("load.ir", 32'(a_ir), 32'h45);
      @(negedge clock);
    end

    // run and step together, 16 adds: the 4-bit counter wraps
    do_reset();
    run = 1'b1; step = 1'b1; instr_valid = 1'b1; mem_ready = 1'b1; instr = 8'h1B;
    @(negedge clock);
    #1;
    chk("runstep.state", 32'(a_state), 32'd1);
    repeat (75) @(negedge clock);
    #1;
    chk("wrap15.w4count", 32'(b_count), 32'd15);
    chk("wrap15.count", 32'(a_count), 32'd15);
    chk("wrap15.state", 32'(a_state), 32'd1);
    repeat (5) @(negedge clock);
    #1;
    chk("wrap16.w4count", 32'(b_count), 32'd0);
    chk("wrap16.count", 32'(a_count), 32'd16);
    chk("wrap16.state", 32'(a_state), 32'd1);

    // stalled store, then reset while in MEM
    step = 1'b0; instr = 8'h80; mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("stall.state", 32'(a_state), 32'd4);
    chk("stall.mem_write", 32'(a_mem_write), 32'd1);
    @(negedge clock);
    do_reset();
    #1;
    check_all("rst_mem", 3'd0, SNone, 0, 1'b0);
    chk("rst_mem.ir", 32'(a_ir), 32'h0);

    // store with mem_ready stuck low: 15 strobe cycles, then fault and HALT
    @(negedge clock);
    run = 1'b1; instr_valid = 1'b1; instr = 8'h80; mem_ready = 1'b0;
    hi = 0;
    for (int i = 0; i < 60 && !a_halted; i++) begin
      @(negedge clock);
      #1;
      if (a_mem_write) hi++;
    end
    chk("fault.wait_cycles", 32'(hi), 32'd15);
    check_all("fault", 3'd7, SNone, 0, 1'b1);
    run = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_all("fault_sticky", 3'd7, SNone, 0, 1'b1);

    // branch -2 retires; self-branch halts without retiring
    do_reset();
    run = 1'b1; instr_valid = 1'b1; instr = 8'hC2; mem_ready = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    check_all("br_m2", 3'd6, SDoneB, 0, 1'b0);
    instr = 8'hC3;
    @(negedge clock);
    #1;
    check_all("self_fetch", 3'd1, SFv, 1, 1'b0);
    repeat (2) @(negedge clock);
    #1;
    check_all("self_exec", 3'd3, SNone, 1, 1'b0);
    @(negedge clock);
    #1;
    check_all("self_halt", 3'd7, SNone, 1, 1'b0);
    chk("self_halt.ir", 32'(a_ir), 32'hC3);
    for (int i = 0; i < 6; i++) begin
      run = i[0]; step = ~i[0];
      @(negedge clock);
      #1;
      chk($sformatf("halt_hold%0d", i), 32'(a_state), 32'd7);
    end
    do_reset();
    #1;
    check_all("halt_exit", 3'd0, SNone, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
